mem_block_copier: RTL and testbench

- Bus initiator for the behavioural word memory: copies `count` 32-bit words from byte address `src` to byte address `dst`.
- Drives the memory's `address`/`memIn`/`read`/`write` ports directly.
- Relies on the memory's combinational read (`memOut` follows `address` while `read`=1) and its posedge-`clk` write.
- Used by test harnesses and the future loader to move data blocks without a CPU.

---
 rtl/mem_copy_pkg.sv | 21 ++
 rtl/mem_range_chk.sv | 29 ++
 rtl/mem_block_copier.sv | 147 ++++++++++++++
 tb/tb_mem_block_copier.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_pkg
// Description : Shared types and constants for the memory block copier.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_copy_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_CAPACITY = 32'h0000_ffff;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_range_chk.sv
`default_nettype none
// ============================================================================
// Module      : mem_range_chk
// Description : Word alignment and end-of-block range check for one address.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_range_chk
    import mem_copy_pkg::*;
#(
    parameter logic [31:0] CAPACITY = DEFAULT_CAPACITY,
    parameter int          CNT_W    = 16
) (
    input  logic [31:0]      base,
    input  logic [CNT_W-1:0] count,
    output logic             aligned,
    output logic             in_range
);

    logic [CNT_W-1:0] w_cnt_m1;
    logic [33:0]      w_last;

    // 34-bit sum so a block wrapping past 2^32 is caught as out of range
    assign w_cnt_m1 = count - CNT_W'(1);
    assign w_last   = {2'b00, base} + ({{(34-CNT_W){1'b0}}, w_cnt_m1} << 2);
    assign aligned  = (base[1:0] == 2'b00);
    assign in_range = (count == '0) || (w_last <= {2'b00, CAPACITY});

endmodule
`default_nettype wire

// File: rtl/mem_block_copier.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_copier
// Description : Forward word-by-word block copy over the behavioural memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_copier
    import mem_copy_pkg::*;
#(
    parameter logic [31:0] CAPACITY = DEFAULT_CAPACITY,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_done,
    output logic [31:0]      address,
    output logic [31:0]      memIn,
    input  logic [31:0]      memOut,
    output logic             read,
    output logic             write
);

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_words;
    logic [31:0]      r_buf;

    logic             w_src_aligned;
    logic             w_src_in_range;
    logic             w_dst_aligned;
    logic             w_dst_in_range;
    logic             w_req_err;
    logic [CNT_W-1:0] w_words_nxt;
    logic [31:0]      w_src_nxt;
    logic [31:0]      w_dst_nxt;

    mem_range_chk #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_src_chk (
        .base     (r_src),
        .count    (r_count),
        .aligned  (w_src_aligned),
        .in_range (w_src_in_range)
    );

    mem_range_chk #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_dst_chk (
        .base     (r_dst),
        .count    (r_count),
        .aligned  (w_dst_aligned),
        .in_range (w_dst_in_range)
    );

    assign w_req_err   = !w_src_aligned || !w_dst_aligned || !w_src_in_range || !w_dst_in_range;
    assign w_words_nxt = r_words + CNT_W'(1);
    assign w_src_nxt   = r_src + 32'(WORD_BYTES);
    assign w_dst_nxt   = r_dst + 32'(WORD_BYTES);

    assign memIn      = r_buf;
    assign words_done = r_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_words <= '0;
            r_buf   <= '0;
            address <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            read    <= 1'b0;
            write   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src   <= src;
                        r_dst   <= dst;
                        r_count <= count;
                        r_words <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_req_err) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_count == '0) begin
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        address <= r_src;
                        read    <= 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_buf   <= memOut;
                    address <= r_dst;
                    read    <= 1'b0;
                    write   <= 1'b1;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    // memory commits the word on this edge
                    r_src   <= w_src_nxt;
                    r_dst   <= w_dst_nxt;
                    r_words <= w_words_nxt;
                    write   <= 1'b0;
                    if (w_words_nxt == r_count) begin
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        address <= w_src_nxt;
                        read    <= 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    read    <= 1'b0;
                    write   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_block_copier.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_copier
// Description : Self-checking bench with behavioural memory and copy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_copier;

    localparam longint c_cap   = 64'h0000_ffff;
    localparam int     c_words = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] count = '0;
    logic        busy, done, err, read, write;
    logic [15:0] words_done;
    logic [31:0] address, memIn, memOut;

    logic [31:0] mem     [0:c_words-1];
    logic [31:0] ref_mem [0:c_words-1];

    int n_checks = 0;
    int n_errors = 0;

    mem_block_copier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .address    (address),
        .memIn      (memIn),
        .memOut     (memOut),
        .read       (read),
        .write      (write)
    );

    always #5 clk = ~clk;

    // behavioural word memory: combinational read, posedge write
    assign memOut = read ? mem[address[15:2]] : 32'h0;
    always @(posedge clk) if (write) mem[address[15:2]] = memIn;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        mem[a[15:2]]     = v;
        ref_mem[a[15:2]] = v;
    endtask

    function automatic bit model_err(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c);
        longint ls = longint'(s);
        longint ld = longint'(d);
        longint lc = longint'(c);
        if (s % 4 != 0 || d % 4 != 0) return 1'b1;
        if (c == 0) return 1'b0;
        return (ls + 4 * (lc - 1) > c_cap) || (ld + 4 * (lc - 1) > c_cap);
    endfunction

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++)
            ref_mem[d / 4 + i] = ref_mem[s / 4 + i];
    endtask

    task automatic chk_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < c_words; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        chk(tag, diffs, 0);
    endtask

    // busy_start_cyc > 0 pulses a conflicting start in that cycle of the copy
    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] c, input int busy_start_cyc);
        bit exp_e;
        int exp_cyc, done_cyc, budget, n_rd, n_wr, n_both;
        logic got_err;
        logic [15:0] got_wd;
        exp_e    = model_err(s, d, c);
        exp_cyc  = (exp_e || c == 0) ? 2 : 2 + 2 * int'(c);
        budget   = exp_cyc + 10;
        done_cyc = -1;
        n_rd = 0; n_wr = 0; n_both = 0;
        got_err = 1'b0; got_wd = '0;
        @(negedge clk);
        src = s; dst = d; count = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_c1"}, busy, 1);
        for (int k = 1; k <= budget; k++) begin
            if (read)  n_rd++;
            if (write) n_wr++;
            if (read && write) n_both++;
            if (k == busy_start_cyc) begin
                start = 1'b1; src = s + 32'h40; dst = d + 32'h200; count = c + 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = k; got_err = err; got_wd = words_done;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_done_cyc"}, done_cyc, exp_cyc);
        chk({tag, "_err"}, got_err, exp_e);
        chk({tag, "_words_done"}, got_wd, exp_e ? 16'd0 : c);
        chk({tag, "_reads"}, n_rd, exp_e ? 0 : int'(c));
        chk({tag, "_writes"}, n_wr, exp_e ? 0 : int'(c));
        chk({tag, "_rd_and_wr"}, n_both, 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_err_hold"}, err, exp_e);
        chk({tag, "_wd_hold"}, words_done, exp_e ? 16'd0 : c);
        if (!exp_e) model_copy(s, d, int'(c));
        chk_mem({tag, "_mem"});
    endtask

    initial begin
        logic [31:0] s, d;
        logic [15:0] c;
        int sel;
        for (int i = 0; i < c_words; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_address", address, 0);
        chk("rst_memIn", memIn, 0);
        chk("rst_words_done", words_done, 0);
        @(negedge clk); rst_n = 1'b1;

        poke(32'h28, 32'h1111_1111);
        poke(32'h2C, 32'h2222_2222);
        poke(32'h30, 32'h3333_3333);
        run_copy("basic", 32'h28, 32'h100, 16'd3, 0);
        chk("basic_w0", mem[32'h100 >> 2], 32'h1111_1111);
        chk("basic_w2", mem[32'h108 >> 2], 32'h3333_3333);

        run_copy("align", 32'h2A, 32'h200, 16'd2, 0);
        run_copy("range", 32'h28, 32'hFFFC, 16'd2, 0);
        run_copy("range_ok", 32'h28, 32'hFFFC, 16'd1, 0);
        run_copy("zero", 32'h28, 32'h300, 16'd0, 0);

        poke(32'h40, 32'hAAAA_AAAA);
        poke(32'h44, 32'hBBBB_BBBB);
        poke(32'h48, 32'hCCCC_CCCC);
        poke(32'h4C, 32'hDDDD_DDDD);
        run_copy("overlap", 32'h40, 32'h44, 16'd3, 0);
        chk("overlap_last", mem[32'h4C >> 2], 32'hAAAA_AAAA);

        run_copy("busy_start", 32'h400, 32'h800, 16'd4, 3);

        // reset during the second write of a 4-word copy
        @(negedge clk);
        src = 32'h1000; dst = 32'h2000; count = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
        end
        chk("rstmid_in_wr2", write, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_read", read, 0);
        chk("rstmid_write", write, 0);
        chk("rstmid_busy", busy, 0);
        model_copy(32'h1000, 32'h2000, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk_mem("rstmid_mem");

        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 9);
            c   = 16'($urandom_range(1, 8));
            s   = 32'($urandom_range(0, 16370)) * 4;
            d   = 32'($urandom_range(0, 16370)) * 4;
            case (sel)
                0: s = s + 32'($urandom_range(1, 3));
                1: d = 32'hFFFF_FFF0;
                2: c = 16'hFFFF;
                3: d = 32'h1_0000 - 32'(4 * int'(c));
                4: d = 32'h1_0000 - 32'(4 * int'(c)) + 32'd4;
                5: c = 16'd0;
                default: ;
            endcase
            run_copy($sformatf("rnd%0d", t), s, d, c, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
